// File: rtl/legv8_ctrl_if.sv
// legv8_ctrl_if: memory handshakes and datapath control lines between sequencer and LEGv8 datapath
interface legv8_ctrl_if;
   logic [31:0] instr;
   logic        imem_ready;
   logic        dmem_ready;
   logic        alu_zero;
   logic        imem_req;
   logic        dmem_req;
   logic        dmem_we;
   logic        ir_we;
   logic        pc_we;
   logic        pc_src;
   logic        reg_we;
   logic        reg2_loc;
   logic        alu_src;
   logic [1:0]  alu_op;
   logic        mem_to_reg;
   logic [1:0]  imm_sel;

   modport master (
      input  instr, imem_ready, dmem_ready, alu_zero,
      output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we,
             reg2_loc, alu_src, alu_op, mem_to_reg, imm_sel
   );

   modport slave (
      output instr, imem_ready, dmem_ready, alu_zero,
      input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we,
             reg2_loc, alu_src, alu_op, mem_to_reg, imm_sel
   );
endinterface

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: multi-cycle FSM sequencing fetch, decode and LEGv8 datapath phases
module legv8_multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   legv8_ctrl_if.master     bus,
   output logic             illegal,
   output logic             busy,
   output logic [CNT_W-1:0] retired
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC_R, ADDR, MEM_RD, MEM_WR, WB_R, WB_LD, BRANCH, HALT
   } state_t;
   typedef enum logic [2:0] {C_R, C_LD, C_ST, C_CBZ, C_B, C_BAD} cls_t;

   state_t      state, state_nx;
   cls_t        cls, cls_dec;
   logic [10:0] op;
   logic [1:0]  imm_q;
   logic        fin;

   // Opcode bits are captured with the fetch so decode does not depend on instr staying valid
   assign cls_dec = (op == 11'b10001011000 || op == 11'b11001011000 ||
                     op == 11'b10001010000 || op == 11'b10101010000) ? C_R :
                    op == 11'b11111000010        ? C_LD  :
                    op == 11'b11111000000        ? C_ST  :
                    op[10:3] == 8'b10110100      ? C_CBZ :
                    op[10:5] == 6'b000101        ? C_B   : C_BAD;

   assign busy = state != IDLE && state != HALT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cls     <= C_R;
         op      <= '0;
         imm_q   <= '0;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         state <= state_nx;
         if (state == FETCH && bus.imem_ready) op <= bus.instr[31:21];
         if (state == DECODE) begin
            cls     <= cls_dec;
            imm_q   <= cls_dec == C_CBZ ? 2'b01 : cls_dec == C_B ? 2'b10 : 2'b00;
            illegal <= illegal | (cls_dec == C_BAD);
         end
         if (fin) retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx       = state;
      fin            = 1'b0;
      bus.imem_req   = 1'b0;
      bus.dmem_req   = 1'b0;
      bus.dmem_we    = 1'b0;
      bus.ir_we      = 1'b0;
      bus.pc_we      = 1'b0;
      bus.pc_src     = 1'b0;
      bus.reg_we     = 1'b0;
      bus.reg2_loc   = 1'b0;
      bus.alu_src    = 1'b0;
      bus.alu_op     = 2'b00;
      bus.mem_to_reg = 1'b0;
      bus.imm_sel    = imm_q;
      case (state)
         IDLE:   state_nx = run ? FETCH : IDLE;
         FETCH: begin
            bus.imem_req = 1'b1;
            bus.ir_we    = bus.imem_ready;
            bus.pc_we    = bus.imem_ready;
            state_nx     = bus.imem_ready ? DECODE : FETCH;
         end
         DECODE: state_nx = cls_dec == C_R ? EXEC_R :
                            (cls_dec == C_LD || cls_dec == C_ST) ? ADDR :
                            (cls_dec == C_CBZ || cls_dec == C_B) ? BRANCH : HALT;
         EXEC_R: begin
            bus.alu_op = 2'b10;
            state_nx   = WB_R;
         end
         WB_R: begin
            bus.reg_we = 1'b1;
            bus.alu_op = 2'b10;
            fin        = 1'b1;
         end
         ADDR: begin
            bus.alu_src  = 1'b1;
            bus.reg2_loc = 1'b1;
            state_nx     = cls == C_ST ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            bus.dmem_req = 1'b1;
            bus.alu_src  = 1'b1;
            state_nx     = bus.dmem_ready ? WB_LD : MEM_RD;
         end
         MEM_WR: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = 1'b1;
            bus.alu_src  = 1'b1;
            bus.reg2_loc = 1'b1;
            fin          = bus.dmem_ready;
         end
         WB_LD: begin
            bus.reg_we     = 1'b1;
            bus.mem_to_reg = 1'b1;
            fin            = 1'b1;
         end
         BRANCH: begin
            bus.reg2_loc = 1'b1;
            bus.alu_op   = 2'b01;
            bus.pc_src   = 1'b1;
            bus.pc_we    = cls == C_B || bus.alu_zero;
            fin          = 1'b1;
         end
         default: ;
      endcase
      if (fin) state_nx = run ? FETCH : IDLE;
   end
endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multi-cycle control sequencer for the LEGv8 core. It fetches each instruction through an instruction-memory handshake and classifies it as R-type, LDUR, STUR, CBZ or B. It then steps the shared datapath (register file, ALU, sign extender, data memory) through the required phases, one phase per state. It drives the sign extender's immediate-type select, which the datapath uses to form D-type, CB-type or B-type immediates.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; start/continue fetching from IDLE
- instr  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_ready  in  1  data memory read data valid / write accepted this cycle
- alu_zero  in  1  ALU zero flag, valid in BRANCH state
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (qualified by dmem_req)
- ir_we  out  1  latch instruction register
- pc_we  out  1  write PC
- pc_src  out  1  0 = PC+4, 1 = branch target (instruction PC + imm<<2, formed by datapath)
- reg_we  out  1  register-file write
- reg2_loc  out  1  1 = read port 2 addressed by Rt (instr[4:0]), 0 = Rm (instr[20:16])
- alu_src  out  1  1 = ALU B operand from sign extender
- alu_op  out  2  00 add, 01 pass-B/zero-test, 10 funct from opcode
- mem_to_reg  out  1  1 = writeback from data memory
- imm_sel  out  2  00 D-type (instr[20:12]), 01 CB-type (instr[23:5]), 10 B-type (instr[25:0])
- illegal  out  1  sticky; unrecognised opcode seen
- busy  out  1  state != IDLE and state != HALT
- retired  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, ADDR, MEM_RD, MEM_WR, WB_R, WB_LD, BRANCH, HALT.
- IDLE: no outputs asserted; the FSM goes to FETCH when run=1.
- FETCH: imem_req=1 while waiting. When imem_ready=1, the cycle asserts ir_we=1, pc_we=1 and pc_src=0, and the FSM goes to DECODE.
- DECODE: registers the opcode class from the IR. Classes are matched in this priority order:
  - instr[31:21] = 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR: R-type, next EXEC_R.
  - 11111000010 (LDUR) or 11111000000 (STUR): next ADDR.
  - instr[31:24] = 10110100 (CBZ): next BRANCH.
  - instr[31:26] = 000101 (B): next BRANCH.
  - Anything else: next HALT, and illegal is set to 1.
- imm_sel is registered in DECODE and held until the next DECODE: 01 for CBZ, 10 for B, 00 otherwise.
- EXEC_R: alu_src=0, alu_op=10, reg2_loc=0; next WB_R.
- WB_R: reg_we=1, mem_to_reg=0, alu_op=10.
- ADDR: alu_src=1, alu_op=00, reg2_loc=1. Next is MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: dmem_req=1, dmem_we=0, alu_src=1, alu_op=00; goes to WB_LD on dmem_ready.
- MEM_WR: dmem_req=1, dmem_we=1, alu_src=1, alu_op=00, reg2_loc=1; goes to FETCH on dmem_ready.
- WB_LD: reg_we=1, mem_to_reg=1.
- BRANCH: reg2_loc=1, alu_op=01, pc_src=1.
  - B: pc_we=1.
  - CBZ: pc_we=alu_zero.
- After WB_R, WB_LD and BRANCH the next state is FETCH if run=1, else IDLE. MEM_WR completion follows the same run rule.
- HALT: no outputs asserted except illegal. Only rst_n leaves HALT.
- retired increments by 1 on the final cycle of each instruction: WB_R, WB_LD, BRANCH, or MEM_WR with dmem_ready. It wraps modulo 2^CNT_W. Illegal instructions are not counted.
- All unlisted outputs are 0 in every state.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, all outputs 0, illegal=0, retired=0, imm_sel=00. The first FETCH is 1 cycle after run is sampled high.
- All control outputs are Moore decodes of state and the registered class. Exceptions: ir_we and the FETCH pc_we are gated by imem_ready; CBZ pc_we is gated by alu_zero.
- Minimum cycles per instruction, with zero-wait memories:
  - R-type: 4 (FETCH, DECODE, EXEC_R, WB_R).
  - LDUR: 5.
  - STUR: 4.
  - CBZ and B: 3.
- Wait states: each extra cycle of imem_ready=0 in FETCH, or dmem_ready=0 in MEM_RD/MEM_WR, adds exactly 1 cycle. Requests stay asserted and stable throughout.
- Ready arriving outside its request state is ignored.
- run deasserted mid-instruction: the instruction completes, then the FSM enters IDLE.
- rst_n asserted mid-instruction: immediate return to IDLE. No reg_we or dmem_we pulse follows.

## Test plan
- ADD X3,X1,X2 (0x8B020023), zero-wait, run=1 → FETCH, DECODE, EXEC_R, WB_R; reg_we high exactly 1 cycle in cycle 4; alu_op=10; retired 0→1.
- LDUR X1,[X2,#8] (0xF8408041), dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; imm_sel=00; WB_LD has reg_we=1 and mem_to_reg=1; total 8 cycles.
- CBZ X5,#4 (0xB4000085): alu_zero=1 → pc_we=1, pc_src=1 in BRANCH, imm_sel=01. alu_zero=0 → no branch pc_we; 3 cycles either way.
- B #-1 (0x17FFFFFF) → imm_sel=10, pc_we=1 and pc_src=1 in BRANCH.
- STUR (0xF8000041) followed by opcode 0x00000000 → store completes with dmem_we=1; then HALT, illegal=1, retired=1; run toggling has no effect until rst_n low.
- rst_n pulsed low during MEM_WR wait → outputs 0 that cycle asynchronously, IDLE, retired=0; preload retired=2^CNT_W-1 and retire one → wraps to 0.
